// File: rtl/imem_dmem_responder_pkg.sv
// Shared types and constants for the instruction/data memory responder.
package imem_dmem_responder_pkg;

  localparam int unsigned DepthLog2Default = 10;
  localparam logic [31:0] NopInst          = 32'h0000_0013;

  localparam int unsigned FetchW = 64;
  localparam int unsigned DataW  = 32;
  localparam int unsigned BeW    = 4;

  typedef enum logic [0:0] {
    StClear,
    StRun
  } state_e;

endpackage

// File: rtl/imem_dmem_responder_if.sv
// Core/host-facing bus of the memory responder: fetch, load/store and loader ports.
interface imem_dmem_responder_if;
  import imem_dmem_responder_pkg::*;

  logic [31:0]       inst_addr;
  logic [FetchW-1:0] inst_data;
  logic              mem_w;
  logic [BeW-1:0]    DWea;
  logic [31:0]       Addr;
  logic [DataW-1:0]  Data_wr;
  logic [DataW-1:0]  Data_rd;
  logic              ld_we;
  logic [31:0]       ld_addr;
  logic [DataW-1:0]  ld_data;
  logic              ready;
  logic              err_misalign;
  logic [15:0]       drop_cnt;

  modport master (
    output inst_addr, mem_w, DWea, Addr, Data_wr, ld_we, ld_addr, ld_data,
    input  inst_data, Data_rd, ready, err_misalign, drop_cnt
  );

  modport slave (
    input  inst_addr, mem_w, DWea, Addr, Data_wr, ld_we, ld_addr, ld_data,
    output inst_data, Data_rd, ready, err_misalign, drop_cnt
  );

endinterface

// File: rtl/imem_dmem_responder_mem_bank.sv
// One 32-bit memory bank: byte-enabled write port, two registered read-first read ports.
module imem_dmem_responder_mem_bank
  import imem_dmem_responder_pkg::*;
#(
  parameter int unsigned      RowW     = 9,
  parameter logic [DataW-1:0] FetchRst = NopInst
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rd_en_i,
  input  logic             we_i,
  input  logic [BeW-1:0]   be_i,
  input  logic [RowW-1:0]  wrow_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [RowW-1:0]  fetch_row_i,
  input  logic [RowW-1:0]  data_row_i,
  output logic [DataW-1:0] fetch_rdata_o,
  output logic [DataW-1:0] data_rdata_o
);

  logic [DataW-1:0] mem_q [2**RowW];
  logic [DataW-1:0] fetch_q, data_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < BeW; i++) begin
        if (be_i[i]) mem_q[wrow_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // While reads are disabled the ports present their idle values instead of array contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_q <= FetchRst;
      data_q  <= '0;
    end else if (rd_en_i) begin
      fetch_q <= mem_q[fetch_row_i];
      data_q  <= mem_q[data_row_i];
    end else begin
      fetch_q <= FetchRst;
      data_q  <= '0;
    end
  end

  assign fetch_rdata_o = fetch_q;
  assign data_rdata_o  = data_q;

endmodule

// File: rtl/imem_dmem_responder.sv
// Memory responder top: clear FSM, address decode, loader/core write arbitration, drop counter.
module imem_dmem_responder
  import imem_dmem_responder_pkg::*;
#(
  parameter int unsigned      DEPTH_LOG2 = DepthLog2Default,
  parameter logic [DataW-1:0] NOP_INST   = NopInst
) (
  input logic                  clk,
  input logic                  rst_n,
  imem_dmem_responder_if.slave bus
);

  localparam int unsigned RowW = DEPTH_LOG2 - 1;

  state_e          state_q, state_d;
  logic [RowW-1:0] clr_cnt_q, clr_cnt_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic [15:0]     drop_q, drop_d;
  logic            rd_sel_q;

  logic                  run;
  logic [RowW-1:0]       fetch_row;
  logic [DEPTH_LOG2-1:0] d_word, ld_word;
  logic                  store_req, conflict;
  logic [DataW-1:0]      fetch_rdata [2];
  logic [DataW-1:0]      data_rdata  [2];
  logic                  unused_addr_bits;

  assign run       = (state_q == StRun);
  assign fetch_row = bus.inst_addr[DEPTH_LOG2+1:3];
  assign d_word    = bus.Addr[DEPTH_LOG2+1:2];
  assign ld_word   = bus.ld_addr[DEPTH_LOG2+1:2];
  assign store_req = bus.mem_w & (bus.Addr[1:0] == 2'b00);
  assign conflict  = run & bus.ld_we & store_req & (ld_word[0] == d_word[0]);

  assign unused_addr_bits = ^{bus.inst_addr[31:DEPTH_LOG2+2], bus.Addr[31:DEPTH_LOG2+2],
                              bus.ld_addr[31:DEPTH_LOG2+2], bus.ld_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= '0;
      rd_sel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
      rd_sel_q  <= d_word[0];
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      StClear: begin
        clr_cnt_d = clr_cnt_q + RowW'(1);
        if (&clr_cnt_q) state_d = StRun;
      end
      StRun: state_d = StRun;
    endcase
  end

  always_comb begin
    ready_d = (state_d == StRun);
    err_d   = (bus.inst_addr[2:0] != 3'b000) | (bus.mem_w & (bus.Addr[1:0] != 2'b00));
    drop_d  = drop_q;
    if (conflict && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic BankSel = (b == 1);

    logic             we;
    logic [BeW-1:0]   be;
    logic [RowW-1:0]  wrow;
    logic [DataW-1:0] wdata;

    // Clear owns the write port; afterwards the loader beats a same-bank core store.
    always_comb begin
      we    = 1'b0;
      be    = '0;
      wrow  = '0;
      wdata = '0;
      if (!run) begin
        we   = 1'b1;
        be   = '1;
        wrow = clr_cnt_q;
      end else if (bus.ld_we && (ld_word[0] == BankSel)) begin
        we    = 1'b1;
        be    = '1;
        wrow  = ld_word[DEPTH_LOG2-1:1];
        wdata = bus.ld_data;
      end else if (store_req && (d_word[0] == BankSel)) begin
        we    = 1'b1;
        be    = bus.DWea;
        wrow  = d_word[DEPTH_LOG2-1:1];
        wdata = bus.Data_wr;
      end
    end

    imem_dmem_responder_mem_bank #(
      .RowW     (RowW),
      .FetchRst (NOP_INST)
    ) u_bank (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .rd_en_i       (run),
      .we_i          (we),
      .be_i          (be),
      .wrow_i        (wrow),
      .wdata_i       (wdata),
      .fetch_row_i   (fetch_row),
      .data_row_i    (d_word[DEPTH_LOG2-1:1]),
      .fetch_rdata_o (fetch_rdata[b]),
      .data_rdata_o  (data_rdata[b])
    );
  end

  assign bus.inst_data    = {fetch_rdata[1], fetch_rdata[0]};
  assign bus.Data_rd      = data_rdata[rd_sel_q];
  assign bus.ready        = ready_q;
  assign bus.err_misalign = err_q;
  assign bus.drop_cnt     = drop_q;

endmodule
